fsm_cmd_sequencer: RTL and testbench



---
 rtl/fsm_cmd_sequencer.sv | 171 +++++++++++++++++
 tb/tb_fsm_cmd_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_cmd_sequencer.sv
// Command sequencer: drives a code onto a controlled FSM's user_input bus, then waits a bounded time for its ack code.
// Optional build macro CMD_SEQ_STICKY_ERR_EN adds the err_sticky output.
module fsm_cmd_sequencer #(
    parameter int         HOLD_W    = 4,
    parameter int         TIMEOUT   = 16,
    parameter logic [2:0] IDLE_CODE = 3'b000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_code,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic [2:0]        cmd_expect,
    output logic [2:0]        user_input,
    input  logic [2:0]        fsm_out,
    output logic              done,
    output logic              timeout_err
`ifdef CMD_SEQ_STICKY_ERR_EN
   ,output logic              err_sticky
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRIVE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_RSVD     = 2'd3
    } state_e;

    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT  = {WAIT_W{1'b1}};
    localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};

    // Stored as a plain 2-bit vector so every encoding, including unreached ones, is representable.
    logic [1:0]        state_q,       state_d;
    logic [HOLD_W-1:0] hold_cnt_q,    hold_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q,    wait_cnt_d;
    logic [2:0]        code_q,        code_d;
    logic [HOLD_W-1:0] hold_q,        hold_d;
    logic [2:0]        expect_q,      expect_d;
    logic [2:0]        user_input_q,  user_input_d;
    logic              cmd_ready_q,   cmd_ready_d;
    logic              done_q,        done_d;
    logic              timeout_err_q, timeout_err_d;

    logic accept;
    logic hold_last;
    logic ack_match;
    logic wait_last;

    assign accept    = cmd_valid && cmd_ready_q;
    assign hold_last = (hold_cnt_q >= hold_q);
    assign ack_match = (fsm_out == expect_q);
    assign wait_last = (wait_cnt_q >= WAIT_LAST);

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        code_d        = code_q;
        hold_d        = hold_q;
        expect_d      = expect_q;
        user_input_d  = IDLE_CODE;
        cmd_ready_d   = 1'b0;
        done_d        = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                hold_cnt_d  = '0;
                wait_cnt_d  = '0;
                if (accept) begin
                    code_d       = cmd_code;
                    hold_d       = cmd_hold;
                    expect_d     = cmd_expect;
                    state_d      = ST_DRIVE;
                    user_input_d = cmd_code;
                    cmd_ready_d  = 1'b0;
                end
            end

            ST_DRIVE: begin
                if (hold_last) begin
                    state_d      = ST_WAIT_ACK;
                    wait_cnt_d   = '0;
                    user_input_d = IDLE_CODE;
                end else begin
                    user_input_d = code_q;
                    if (hold_cnt_q != HOLD_SAT) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end

            ST_WAIT_ACK: begin
                // A match on the final allowed cycle takes priority over the timeout.
                if (ack_match) begin
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                    hold_cnt_d  = '0;
                    wait_cnt_d  = '0;
                end else if (wait_last) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                    cmd_ready_d   = 1'b1;
                    hold_cnt_d    = '0;
                    wait_cnt_d    = '0;
                end else if (wait_cnt_q != WAIT_SAT) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                hold_cnt_d  = '0;
                wait_cnt_d  = '0;
            end
        endcase
    end

`ifdef CMD_SEQ_STICKY_ERR_EN
    logic err_sticky_q, err_sticky_d;

    always_comb begin
        err_sticky_d = err_sticky_q | timeout_err_d | (state_q == ST_RSVD);
    end

    assign err_sticky = err_sticky_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            hold_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            user_input_q  <= IDLE_CODE;
            cmd_ready_q   <= 1'b1;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef CMD_SEQ_STICKY_ERR_EN
            err_sticky_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            user_input_q  <= user_input_d;
            cmd_ready_q   <= cmd_ready_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
`ifdef CMD_SEQ_STICKY_ERR_EN
            err_sticky_q  <= err_sticky_d;
`endif
        end
        // Captured command fields are only read after a capture, so they need no reset.
        code_q   <= code_d;
        hold_q   <= hold_d;
        expect_q <= expect_d;
    end

    assign cmd_ready   = cmd_ready_q;
    assign user_input  = user_input_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fsm_cmd_sequencer.sv
// Directed bench for fsm_cmd_sequencer: hand-computed cycle-exact expectations per scenario.
module tb_fsm_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_code;
    logic [3:0] cmd_hold;
    logic [2:0] cmd_expect;
    logic [2:0] user_input;
    logic [2:0] fsm_out;
    logic       done;
    logic       timeout_err;
`ifdef CMD_SEQ_STICKY_ERR_EN
    logic       err_sticky;
`endif

    int n_cmp = 0;
    int n_mis = 0;
    int pulses;

    fsm_cmd_sequencer #(
        .HOLD_W   (4),
        .TIMEOUT  (16),
        .IDLE_CODE(3'b000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_code   (cmd_code),
        .cmd_hold   (cmd_hold),
        .cmd_expect (cmd_expect),
        .user_input (user_input),
        .fsm_out    (fsm_out),
        .done       (done),
        .timeout_err(timeout_err)
`ifdef CMD_SEQ_STICKY_ERR_EN
       ,.err_sticky (err_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] c, input logic [3:0] h, input logic [2:0] e);
        cmd_valid  = 1'b1;
        cmd_code   = c;
        cmd_hold   = h;
        cmd_expect = e;
        tick();
        cmd_valid  = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_code   = 3'b000;
        cmd_hold   = 4'd0;
        cmd_expect = 3'b000;
        fsm_out    = 3'b111;
        tick();
        tick();
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_user", 32'(user_input), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_tmo", 32'(timeout_err), 32'd0);
`ifdef CMD_SEQ_STICKY_ERR_EN
        check_eq("rst_sticky", 32'(err_sticky), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Basic command, with a busy-time pulse that must be ignored
        send(3'b011, 4'd2, 3'b001);
        check_eq("basic_t1_user", 32'(user_input), 32'h3);
        check_eq("basic_t1_ready", 32'(cmd_ready), 32'd0);
        tick();
        check_eq("basic_t2_user", 32'(user_input), 32'h3);
        cmd_valid = 1'b1; cmd_code = 3'b110; cmd_hold = 4'd0; cmd_expect = 3'b111;
        tick();
        cmd_valid = 1'b0;
        check_eq("basic_t3_user", 32'(user_input), 32'h3);
        tick();
        check_eq("basic_t4_user", 32'(user_input), 32'h0);
        check_eq("basic_t4_done", 32'(done), 32'd0);
        tick();
        check_eq("basic_t5_done", 32'(done), 32'd0);
        fsm_out = 3'b001;
        tick();
        check_eq("basic_t6_done", 32'(done), 32'd1);
        check_eq("basic_t6_ready", 32'(cmd_ready), 32'd1);
        check_eq("basic_t6_tmo", 32'(timeout_err), 32'd0);
        fsm_out = 3'b111;
        tick();
        check_eq("basic_t7_done", 32'(done), 32'd0);

        // Timeout: hold=0, never matched
        send(3'b110, 4'd0, 3'b010);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            pulses += int'(done) + int'(timeout_err);
        end
        check_eq("tmo_early_pulses", 32'(pulses), 32'd0);
        tick();
        check_eq("tmo_t18_tmo", 32'(timeout_err), 32'd1);
        check_eq("tmo_t18_done", 32'(done), 32'd0);
        check_eq("tmo_t18_ready", 32'(cmd_ready), 32'd1);
`ifdef CMD_SEQ_STICKY_ERR_EN
        check_eq("tmo_sticky", 32'(err_sticky), 32'd1);
`endif
        tick();
        check_eq("tmo_t19_tmo", 32'(timeout_err), 32'd0);

        // Match arriving in the 16th WAIT_ACK cycle
        send(3'b010, 4'd0, 3'b100);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            pulses += int'(done) + int'(timeout_err);
        end
        check_eq("bnd_early_pulses", 32'(pulses), 32'd0);
        fsm_out = 3'b100;
        tick();
        check_eq("bnd_done", 32'(done), 32'd1);
        check_eq("bnd_tmo", 32'(timeout_err), 32'd0);
        fsm_out = 3'b111;
        tick();
        check_eq("bnd_after_done", 32'(done), 32'd0);

        // Back-to-back with cmd_valid held high
        cmd_valid = 1'b1; cmd_code = 3'b001; cmd_hold = 4'd1; cmd_expect = 3'b011;
        fsm_out = 3'b011;
        tick();
        check_eq("b2b_t1_user", 32'(user_input), 32'h1);
        cmd_code = 3'b010; cmd_hold = 4'd0; cmd_expect = 3'b101;
        tick();
        check_eq("b2b_t2_user", 32'(user_input), 32'h1);
        tick();
        check_eq("b2b_t3_user", 32'(user_input), 32'h0);
        tick();
        check_eq("b2b_t4_done", 32'(done), 32'd1);
        check_eq("b2b_t4_ready", 32'(cmd_ready), 32'd1);
        tick();
        check_eq("b2b_t5_user", 32'(user_input), 32'h2);
        check_eq("b2b_t5_ready", 32'(cmd_ready), 32'd0);
        check_eq("b2b_t5_done", 32'(done), 32'd0);
        cmd_valid = 1'b0;
        fsm_out = 3'b101;
        tick();
        check_eq("b2b_t6_user", 32'(user_input), 32'h0);
        tick();
        check_eq("b2b_t7_done", 32'(done), 32'd1);
        fsm_out = 3'b111;
        tick();

        // Reset mid-DRIVE
        send(3'b101, 4'd15, 3'b001);
        check_eq("mrst_drive_user", 32'(user_input), 32'h5);
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_eq("mrst_user", 32'(user_input), 32'h0);
        check_eq("mrst_ready", 32'(cmd_ready), 32'd1);
        check_eq("mrst_done", 32'(done), 32'd0);
        check_eq("mrst_tmo", 32'(timeout_err), 32'd0);
`ifdef CMD_SEQ_STICKY_ERR_EN
        check_eq("mrst_sticky", 32'(err_sticky), 32'd0);
`endif
        fsm_out = 3'b001;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(done) + int'(timeout_err) + int'(user_input != 3'b000);
        end
        check_eq("mrst_quiet", 32'(pulses), 32'd0);
        fsm_out = 3'b111;

        // Illegal state forced mid-DRIVE
        send(3'b111, 4'd10, 3'b001);
        check_eq("ill_drive_user", 32'(user_input), 32'h7);
        tick();
        force dut.state_q = 2'b11;
        #1;
        release dut.state_q;
        tick();
        check_eq("ill_user", 32'(user_input), 32'h0);
        check_eq("ill_ready", 32'(cmd_ready), 32'd1);
        check_eq("ill_pulses", 32'(int'(done) + int'(timeout_err)), 32'd0);
`ifdef CMD_SEQ_STICKY_ERR_EN
        check_eq("ill_sticky", 32'(err_sticky), 32'd1);
`endif
        tick();
        check_eq("ill_idle_user", 32'(user_input), 32'h0);
        check_eq("ill_idle_ready", 32'(cmd_ready), 32'd1);

        // Successful command afterwards
        fsm_out = 3'b001;
        send(3'b011, 4'd0, 3'b001);
        check_eq("post_user", 32'(user_input), 32'h3);
        tick();
        tick();
        check_eq("post_done", 32'(done), 32'd1);
`ifdef CMD_SEQ_STICKY_ERR_EN
        check_eq("post_sticky", 32'(err_sticky), 32'd1);
`endif
        fsm_out = 3'b111;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
